// File: rtl/alu_mul_sequencer.sv
// Shift-add multiply sequencer that borrows the shared ALU for WIDTH cycles.
// Returns either the low or high word of the unsigned 2*WIDTH-bit product.
module alu_mul_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter logic [3:0]  OPC_ADD = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sel_hi,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  output logic             alu_own,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             own_q, own_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      count_q  <= '0;
      sel_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      own_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      count_q  <= count_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      own_q    <= own_d;
      result_q <= result_d;
    end
  end

  // The ALU has no carry-out, so recover it from unsigned wrap-around
  assign carry = (alu_y < hi_q);

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    count_d  = count_q;
    sel_d    = sel_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = op_a;
          lo_d    = op_b;
          hi_d    = '0;
          count_d = '0;
          sel_d   = sel_hi;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        hi_d    = {carry, alu_y[WIDTH-1:1]};
        lo_d    = {alu_y[0], lo_q[WIDTH-1:1]};
        count_d = CW'(count_q + 1'b1);
        if (count_q == LAST_STEP) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = sel_q ? hi_d : lo_d;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    own_d  = (state_d == S_RUN);
  end

  // ALU drive depends only on registered state, never on start
  assign alu_own    = own_q;
  assign alu_opcode = own_q ? OPC_ADD : 4'b0000;
  assign alu_a      = own_q ? hi_q : '0;
  assign alu_b      = (own_q && lo_q[0]) ? mcand_q : '0;

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer: stimulus pushes expectations,
// a negedge monitor pops and checks them when done pulses.
module tb_alu_mul_sequencer;

  localparam int unsigned W = 32;
  localparam int LAT = 33;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sel_hi;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [3:0]   alu_opcode;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_y;
  logic         alu_own;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  typedef struct {
    logic [W-1:0] res;
    int           stamp;
  } exp_t;

  exp_t         exp_q[$];
  int           cyc;
  int           checks;
  int           errors;
  int           own_cnt;
  int           wait_cnt;
  logic [W-1:0] last_res;

  alu_mul_sequencer #(.WIDTH(W), .OPC_ADD(4'b0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .sel_hi     (sel_hi),
    .op_a       (op_a),
    .op_b       (op_b),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_y      (alu_y),
    .alu_own    (alu_own),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  // Shared ALU performing ADD
  assign alu_y = alu_a + alu_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: all comparisons happen here
  initial begin
    checks   = 0;
    errors   = 0;
    own_cnt  = 0;
    wait_cnt = 0;
    last_res = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_busy",    W'(busy),    '0);
        chk("rst_done",    W'(done),    '0);
        chk("rst_alu_own", W'(alu_own), '0);
        chk("rst_result",  result,      '0);
        exp_q.delete();
        own_cnt  = 0;
        wait_cnt = 0;
        last_res = '0;
      end else begin
        if (alu_own) own_cnt++;
        if (done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done: done=1 with no pending op, result 0x%08h", result);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result",     result,              e.res);
            chk("latency",    W'(cyc - e.stamp),   W'(LAT));
            chk("own_cycles", W'(own_cnt),         W'(W));
            chk("done_busy",  W'(busy),            W'(1));
            chk("done_own",   W'(alu_own),         '0);
            chk("done_alu_a", alu_a,               '0);
            chk("done_alu_b", alu_b,               '0);
            last_res = e.res;
          end
          own_cnt  = 0;
          wait_cnt = 0;
        end else if (exp_q.size() != 0) begin
          wait_cnt++;
          if (wait_cnt == 20) begin
            chk("mid_own",    W'(alu_own),    W'(1));
            chk("mid_opcode", W'(alu_opcode), '0);
            chk("mid_hold",   result,         last_res);
          end
          if (wait_cnt > 60) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done after %0d cycles, got busy=%0d expected done", wait_cnt, busy);
            void'(exp_q.pop_front());
            wait_cnt = 0;
            own_cnt  = 0;
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] exp);
    wait_idle();
    start  = 1'b1;
    op_a   = a;
    op_b   = b;
    sel_hi = s;
    exp_q.push_back('{res: exp, stamp: cyc});
    @(negedge clk);
    start  = 1'b0;
    op_a   = ~a;
    op_b   = b ^ 32'h5A5A_A5A5;
    sel_hi = ~s;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        $display("FAIL drain: scoreboard stuck with %0d pending", exp_q.size());
        $fatal(1, "bench stalled");
      end
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] exp);
    issue(a, b, s, exp);
    drain();
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    sel_hi = 1'b0;
    op_a   = '0;
    op_b   = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    run_op(32'd3, 32'd5, 1'b0, 32'd15);
    run_op(32'd3, 32'd5, 1'b1, 32'd0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE);
    run_op(32'h8000_0000, 32'd2, 1'b0, 32'h0000_0000);
    run_op(32'h8000_0000, 32'd2, 1'b1, 32'h0000_0001);
    run_op(32'd0, 32'h1234_5678, 1'b0, 32'd0);
    run_op(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 32'hFFFE_0001);
    run_op(32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0001);
    run_op(32'd7, 32'd6, 1'b0, 32'd42);

    // A second start mid-RUN must be ignored
    issue(32'd3, 32'd5, 1'b0, 32'd15);
    repeat (5) @(negedge clk);
    start  = 1'b1;
    op_a   = 32'd7;
    op_b   = 32'd7;
    sel_hi = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    drain();

    // Asynchronous reset in the middle of a run, then a fresh op
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run_op(32'd7, 32'd6, 1'b0, 32'd42);
    run_op(32'd12, 32'd11, 1'b0, 32'd132);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
